// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler driving the DDS tuning word from byte-programmed START/STOP/STEP/DWELL.
// Latency: first tuning word one clock after an accepted start; each word held DWELL+1 enabled clocks.
// Backpressure: none; ena low freezes all state and suppresses the tw_update/done pulses.
module dds_sweep_ctrl #(
    parameter int TW      = 14,
    parameter int DWELL_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic          abort,
    output logic [TW-1:0] tuning_word,
    output logic          tw_update,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);
    // The step to the next word happens on the same edge the dwell expires,
    // so there is no separate step state in the encoding.
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [TW-1:0]        a_start_q, a_start_d, a_stop_q, a_stop_d, a_step_q, a_step_d;
    logic [DWELL_W-1:0]   a_dwell_q, a_dwell_d, cnt_q, cnt_d;
    logic [1:0]           a_mode_q, a_mode_d;
    logic [TW-1:0]        tw_q, tw_d;
    logic                 dir_q, dir_d, upd_q, upd_d, busy_q, busy_d;
    logic                 done_q, done_d, err_q, err_d;

    logic [15:0]          wbuf;
    logic                 cfg_ok, go, expire, at_stop, single;
    logic [TW:0]          up_sum, dn_lim;
    logic [TW-1:0]        up_next, dn_next;

    assign cfg_ok  = (step_q != '0) && (start_q <= stop_q);
    assign go      = start && !abort && cfg_ok;
    assign expire  = (cnt_q == '0);
    assign at_stop = !dir_q && (tw_q == a_stop_q);
    assign single  = (a_mode_q == 2'd0) || (a_mode_q == 2'd3);

    // Sums are one bit wider so a large STEP clamps instead of wrapping.
    assign up_sum  = {1'b0, tw_q} + {1'b0, a_step_q};
    assign dn_lim  = {1'b0, a_start_q} + {1'b0, a_step_q};
    assign up_next = (up_sum >= {1'b0, a_stop_q}) ? a_stop_q : up_sum[TW-1:0];
    assign dn_next = ({1'b0, tw_q} <= dn_lim) ? a_start_q : (tw_q - a_step_q);

    always_comb begin
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        wbuf    = 16'h0;
        if (wr_en) begin
            case (wr_addr[2:1])
                2'd0:    wbuf = 16'(start_q);
                2'd1:    wbuf = 16'(stop_q);
                2'd2:    wbuf = 16'(step_q);
                default: wbuf = 16'(dwell_q);
            endcase
            if (wr_addr[0]) wbuf[15:8] = wr_data;
            else            wbuf[7:0]  = wr_data;
            case (wr_addr[2:1])
                2'd0:    start_d = wbuf[TW-1:0];
                2'd1:    stop_d  = wbuf[TW-1:0];
                2'd2:    step_d  = wbuf[TW-1:0];
                default: dwell_d = DWELL_W'(wbuf);
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_DWELL;
            S_DWELL: begin
                if (abort)                              state_d = S_IDLE;
                else if (expire && at_stop && single)   state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_start_d = a_start_q;
        a_stop_d  = a_stop_q;
        a_step_d  = a_step_q;
        a_dwell_d = a_dwell_q;
        a_mode_d  = a_mode_q;
        cnt_d     = cnt_q;
        tw_d      = tw_q;
        dir_d     = dir_q;
        busy_d    = busy_q;
        err_d     = err_q;
        upd_d     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        a_start_d = start_q;
                        a_stop_d  = stop_q;
                        a_step_d  = step_q;
                        a_dwell_d = dwell_q;
                        a_mode_d  = mode;
                        tw_d      = start_q;
                        upd_d     = 1'b1;
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
                        dir_d     = 1'b0;
                    end else begin
                        err_d     = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                if (abort) begin
                    busy_d = 1'b0;
                end else if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (dir_q) begin
                    upd_d = 1'b1;
                    if (tw_q == a_start_q) begin
                        dir_d = 1'b0;
                        tw_d  = up_next;
                    end else begin
                        tw_d  = dn_next;
                    end
                end else if (!at_stop) begin
                    upd_d = 1'b1;
                    tw_d  = up_next;
                end else if (a_mode_q == 2'd1) begin
                    upd_d = 1'b1;
                    tw_d  = a_start_q;
                end else if (a_mode_q == 2'd2) begin
                    upd_d = 1'b1;
                    dir_d = 1'b1;
                    tw_d  = dn_next;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (upd_d) cnt_d = (state_q == S_IDLE) ? dwell_q : a_dwell_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            a_start_q <= '0;
            a_stop_q  <= '0;
            a_step_q  <= '0;
            a_dwell_q <= '0;
            a_mode_q  <= '0;
            cnt_q     <= '0;
            tw_q      <= '0;
            dir_q     <= 1'b0;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            upd_q  <= ena & upd_d;
            done_q <= ena & done_d;
            if (ena) begin
                state_q   <= state_d;
                start_q   <= start_d;
                stop_q    <= stop_d;
                step_q    <= step_d;
                dwell_q   <= dwell_d;
                a_start_q <= a_start_d;
                a_stop_q  <= a_stop_d;
                a_step_q  <= a_step_d;
                a_dwell_q <= a_dwell_d;
                a_mode_q  <= a_mode_d;
                cnt_q     <= cnt_d;
                tw_q      <= tw_d;
                dir_q     <= dir_d;
                busy_q    <= busy_d;
                err_q     <= err_d;
            end
        end
    end

    assign tuning_word = tw_q;
    assign tw_update   = upd_q & ena;
    assign done        = done_q & ena;
    assign busy        = busy_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected tuning words are queued at start and popped on tw_update.
// Hold length between updates and the status outputs are checked at each step.
module tb_dds_sweep_ctrl;
    localparam int TW = 14;

    logic          clk = 1'b0;
    logic          rst_n, ena, wr_en, start, abort;
    logic [2:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [1:0]    mode;
    logic [TW-1:0] tuning_word;
    logic          tw_update, busy, done, cfg_err;

    int total = 0;
    int bad   = 0;
    int sb[$];

    dds_sweep_ctrl #(.TW(TW), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mode(mode), .start(start), .abort(abort),
        .tuning_word(tuning_word), .tw_update(tw_update), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic cfg(input int s, input int p, input int st, input int dw);
        logic [31:0] v;
        v = 32'(s);  wr(3'd0, v[7:0]); wr(3'd1, v[15:8]);
        v = 32'(p);  wr(3'd2, v[7:0]); wr(3'd3, v[15:8]);
        v = 32'(st); wr(3'd4, v[7:0]); wr(3'd5, v[15:8]);
        v = 32'(dw); wr(3'd6, v[7:0]); wr(3'd7, v[15:8]);
    endtask

    task automatic go(input logic [1:0] m);
        mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pops one expected word per tw_update and checks each word was held dw+1 cycles.
    task automatic collect(input int n, input int dw, input string tag);
        int got = 0;
        int hold = 0;
        int t = 0;
        int exp_tw;
        while (got < n && t < 2000) begin
            if (tw_update) begin
                exp_tw = (sb.size() > 0) ? sb.pop_front() : -1;
                chk({tag, "_tw"}, 32'(tuning_word), 32'(exp_tw));
                if (got > 0) chk({tag, "_hold"}, 32'(hold), 32'(dw + 1));
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                got++;
                hold = 0;
            end
            if (got < n) begin
                tick();
                wr_en = 1'b0;
                hold++;
                t++;
            end
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
        mode = 2'd0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_tw", 32'(tuning_word), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_upd", 32'(tw_update), 32'd0);

        // Rejected starts: STEP=0 after reset, then START > STOP.
        go(2'd0);
        chk("err_step0", 32'(cfg_err), 32'd1);
        chk("err_step0_busy", 32'(busy), 32'd0);
        chk("err_step0_upd", 32'(tw_update), 32'd0);
        cfg(50, 40, 10, 2);
        go(2'd0);
        chk("err_order", 32'(cfg_err), 32'd1);
        chk("err_order_busy", 32'(busy), 32'd0);
        chk("err_order_tw", 32'(tuning_word), 32'd0);

        // Single sweep 100..130 step 10 dwell 2.
        cfg(100, 130, 10, 2);
        sb = '{100, 110, 120, 130};
        go(2'd0);
        chk("single_err_clr", 32'(cfg_err), 32'd0);
        collect(4, 2, "single");
        tick();
        tick();
        chk("single_pre_done", 32'(done), 32'd0);
        chk("single_pre_busy", 32'(busy), 32'd1);
        tick();
        chk("single_done", 32'(done), 32'd1);
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_tw_hold", 32'(tuning_word), 32'd130);
        tick();
        chk("single_done_pulse", 32'(done), 32'd0);
        chk("single_tw_after", 32'(tuning_word), 32'd130);

        // Clamped last step.
        cfg(0, 25, 10, 0);
        sb = '{0, 10, 20, 25};
        go(2'd3);
        collect(4, 0, "clamp");
        tick();
        chk("clamp_done", 32'(done), 32'd1);
        chk("clamp_tw", 32'(tuning_word), 32'd25);

        // Triangle, then abort.
        cfg(10, 30, 10, 0);
        sb = '{10, 20, 30, 20, 10, 20, 30};
        go(2'd2);
        collect(7, 0, "tri");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("tri_abort_busy", 32'(busy), 32'd0);
        chk("tri_abort_tw", 32'(tuning_word), 32'd30);
        chk("tri_abort_done", 32'(done), 32'd0);

        // Sawtooth with a STOP rewrite while busy, then abort.
        sb = '{10, 20, 30, 10, 20, 30};
        go(2'd1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd200;
        collect(6, 0, "saw");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("saw_abort_busy", 32'(busy), 32'd0);
        chk("saw_abort_done", 32'(done), 32'd0);
        tick();
        chk("saw_frozen_tw", 32'(tuning_word), 32'd30);

        // Start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_upd", 32'(tw_update), 32'd0);
        tick();
        chk("sa_tw", 32'(tuning_word), 32'd30);

        // ena dropped for 5 cycles mid-dwell.
        cfg(100, 130, 10, 4);
        go(2'd0);
        chk("ena_first_tw", 32'(tuning_word), 32'd100);
        tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ena_gap_upd", 32'(tw_update), 32'd0);
            chk("ena_gap_done", 32'(done), 32'd0);
        end
        ena = 1'b1;
        n = 6;
        while (!tw_update && n < 60) begin
            tick();
            n++;
        end
        chk("ena_dwell_len", 32'(n), 32'd10);
        chk("ena_next_tw", 32'(tuning_word), 32'd110);

        // Asynchronous reset mid-sweep.
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_tw", 32'(tuning_word), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_upd", 32'(tw_update), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(cfg_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        go(2'd0);
        chk("arst_cfg_cleared", 32'(cfg_err), 32'd1);
        chk("arst_cfg_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
